// File: rtl/mod_updown_counter.sv
// Modulo-N synchronous up/down counter with parallel load, wrap/saturate mode,
// a combinational cascade terminal count and a saturating wrap event counter.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_dn,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              wrap,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0]  MAX_Q    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]    MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0]  q_reg, q_next;
  logic              wrap_reg, wrap_next;
  logic              load_err_reg, load_err_next;
  logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;

  logic at_max, at_min, limit, load_ok;

  assign at_max  = (q_reg == MAX_Q);
  assign at_min  = (q_reg == '0);
  assign limit   = en & (up_dn ? at_max : at_min);
  // One bit wider so MODULUS == 2**WIDTH still compares correctly.
  assign load_ok = ({1'b0, load_val} < MOD_EXT);

  always_comb begin
    q_next        = q_reg;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    wrap_cnt_next = wrap_cnt_reg;
    if (clear) begin
      q_next        = '0;
      wrap_cnt_next = '0;
    end else if (load) begin
      if (load_ok) begin
        q_next = load_val;
      end else begin
        q_next        = MAX_Q;
        load_err_next = 1'b1;
      end
    end else if (en) begin
      if (limit) begin
        wrap_next = 1'b1;
        if (wrap_cnt_reg != WRAP_MAX) begin
          wrap_cnt_next = wrap_cnt_reg + 1'b1;
        end
        if (SATURATE == 0) begin
          q_next = up_dn ? '0 : MAX_Q;
        end
      end else begin
        q_next = up_dn ? (q_reg + 1'b1) : (q_reg - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= '0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      wrap_cnt_reg <= '0;
    end else begin
      q_reg        <= q_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
      wrap_cnt_reg <= wrap_cnt_next;
    end
  end

  assign q        = q_reg;
  assign tc       = limit;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;
  assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are compared every cycle against a behavioural model, plus directed checks.
module tb_mod_updown_counter;

  typedef struct {
    int q;
    int wrap;
    int load_err;
    int wc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       wr0, wr1, wr2;
  logic       le0, le1, le2;
  logic [7:0] wc0, wc1;
  logic [1:0] wc2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Index 0: wrap mode, 1: saturate mode, 2: narrow wrap event counter.
  int   mod_c  [3] = '{10, 10, 10};
  bit   sat_c  [3] = '{1'b0, 1'b1, 1'b0};
  int   wmax_c [3] = '{255, 255, 3};
  exp_t m [3];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .WRAP_W(8)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .wrap(wr0), .load_err(le0), .wrap_cnt(wc0));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .WRAP_W(8)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .wrap(wr1), .load_err(le1), .wrap_cnt(wc1));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .WRAP_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .q(q2), .tc(tc2), .wrap(wr2), .load_err(le2), .wrap_cnt(wc2));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic exp_t observe(input int i);
    exp_t o;
    case (i)
      0:       o = '{int'(q0), int'(wr0), int'(le0), int'(wc0)};
      1:       o = '{int'(q1), int'(wr1), int'(le1), int'(wc1)};
      default: o = '{int'(q2), int'(wr2), int'(le2), int'(wc2)};
    endcase
    return o;
  endfunction

  function automatic int observe_tc(input int i);
    case (i)
      0:       return int'(tc0);
      1:       return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int model_tc(input exp_t s, input logic e, input logic u, input int md);
    if (!e) return 0;
    return u ? int'(s.q == md - 1) : int'(s.q == 0);
  endfunction

  function automatic exp_t model_next(input exp_t s, input logic r, input logic e,
                                      input logic u, input logic c, input logic l,
                                      input int lv, input int md, input bit sat,
                                      input int wmax);
    exp_t n = s;
    n.wrap = 0;
    n.load_err = 0;
    if (r) begin
      n = '{0, 0, 0, 0};
    end else if (c) begin
      n.q = 0;
      n.wc = 0;
    end else if (l) begin
      if (lv < md) n.q = lv;
      else begin
        n.q = md - 1;
        n.load_err = 1;
      end
    end else if (e) begin
      if (model_tc(s, e, u, md) == 1) begin
        n.wrap = 1;
        if (s.wc < wmax) n.wc = s.wc + 1;
        if (!sat) n.q = u ? 0 : md - 1;
      end else begin
        n.q = u ? s.q + 1 : s.q - 1;
      end
    end
    return n;
  endfunction

  // One clock cycle: drive, check tc before the edge, push expectations, compare after.
  task automatic step(input logic r, input logic e, input logic u, input logic c,
                      input logic l, input logic [3:0] lv);
    exp_t o, x;
    @(negedge clk);
    rst = r; en = e; up_dn = u; clear = c; load = l; load_val = lv;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tc[%0d]", i), observe_tc(i), model_tc(m[i], e, u, mod_c[i]));
      m[i] = model_next(m[i], r, e, u, c, l, int'(lv), mod_c[i], sat_c[i], wmax_c[i]);
      exp_q.push_back(m[i]);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      o = observe(i);
      x = exp_q.pop_front();
      check($sformatf("q[%0d]", i), o.q, x.q);
      check($sformatf("wrap[%0d]", i), o.wrap, x.wrap);
      check($sformatf("load_err[%0d]", i), o.load_err, x.load_err);
      check($sformatf("wrap_cnt[%0d]", i), o.wc, x.wc);
    end
    $display("cyc %0d rst=%0b en=%0b up=%0b clr=%0b ld=%0b lv=%0d -> q=%0d/%0d/%0d wc=%0d/%0d/%0d",
             cyc, r, e, u, c, l, lv, q0, q1, q2, wc0, wc1, wc2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};

    // Reset two cycles, then idle.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("t1_q", int'(q0), 0);
    check("t1_wrap_cnt", int'(wc0), 0);
    check("t1_tc_idle", int'(tc0), 0);

    // Count up 12 edges from 0.
    for (int k = 0; k < 12; k++) step(0, 1, 1, 0, 0, 0);
    check("t2_q", int'(q0), 2);
    check("t2_wrap_cnt", int'(wc0), 1);
    check("t2_sat_q", int'(q1), 9);
    check("t2_sat_wrap_cnt", int'(wc1), 3);

    // Load 2 and count down 4 edges.
    step(0, 0, 1, 0, 1, 4'd2);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0);
    check("t3_q", int'(q0), 8);
    check("t3_wrap_cnt", int'(wc0), 2);

    // Saturate mode: up from 8 after a clear.
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1, 4'd8);
    for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 0, 0);
    check("t4_sat_q", int'(q1), 9);
    check("t4_sat_wrap_cnt", int'(wc1), 3);

    // Out-of-range load clamps and flags; in-range load does not.
    step(0, 0, 1, 0, 1, 4'd12);
    check("t5_q_clamp", int'(q0), 9);
    check("t5_load_err", int'(le0), 1);
    step(0, 0, 1, 0, 1, 4'd5);
    check("t5_q_load", int'(q0), 5);
    check("t5_load_err_clr", int'(le0), 0);

    // Priority: clear beats load and en; rst beats everything; rst mid-count.
    step(0, 1, 1, 1, 1, 4'd7);
    check("t6_clear_q", int'(q0), 0);
    check("t6_clear_wc", int'(wc0), 0);
    step(0, 0, 1, 0, 1, 4'd4);
    step(1, 1, 1, 1, 1, 4'd3);
    check("t6_rst_q", int'(q0), 0);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0, 0);
    check("t6_mid_q", int'(q0), 6);
    step(1, 1, 1, 0, 0, 0);
    check("t6_mid_rst_q", int'(q0), 0);

    // Five wraps: narrow counter sticks at 3.
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 1, 4'd9);
      step(0, 1, 1, 0, 0, 0);
    end
    check("t6_w2_wrap_cnt", int'(wc2), 3);
    check("t6_w8_wrap_cnt", int'(wc0), 5);

    // Mixed random traffic, still compared cycle by cycle.
    for (int k = 0; k < 200; k++) begin
      logic [3:0] rv;
      int sel;
      rv  = 4'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 99));
      step(sel < 2, sel < 85, 1'($urandom_range(0, 1)), sel >= 97, sel >= 88 && sel < 97, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
